tri_job_scheduler: RTL

Job scheduler in front of the triangle rasterizer engine. It accepts triangle jobs from NREQ requesters and picks one at a time with round-robin arbitration. It feeds the chosen job's three vertices to the engine using the engine's nt/xi/yi three-cycle load protocol, then forwards every emitted point tagged with the owner's index. When the engine finishes, it returns a done pulse and a point count to the owner.

---
 rtl/tri_job_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/tri_job_scheduler.sv
// tri_job_scheduler: round-robin job scheduler in front of the triangle
// rasterizer engine. It grants one requester at a time and loads that
// requester's three vertices with the nt/xi/yi protocol. It forwards engine
// points tagged with the owner's index, then returns done plus a point count.
// Optional feature: define TRI_SCHED_WDOG_EN to abort jobs that stay in
// WAITB/RUN for WDOG_CYC cycles. An aborted job reports err with its done.
module tri_job_scheduler #(
  parameter int NREQ     = 2,
  parameter int WDOG_CYC = 1023,
  localparam int OW      = (NREQ < 3) ? 1 : $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*18-1:0] req_vtx,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [6:0]        pt_cnt,
  output logic              pt_valid,
  output logic [2:0]        pt_x,
  output logic [2:0]        pt_y,
  output logic [OW-1:0]     pt_owner,
  output logic              eng_nt,
  output logic [2:0]        eng_xi,
  output logic [2:0]        eng_yi,
  input  logic              eng_busy,
  input  logic              eng_po,
  input  logic [2:0]        eng_xo,
  input  logic [2:0]        eng_yo
);

  typedef enum logic [2:0] {IDLE, LD1, LD2, LD3, WAITB, RUN, FIN} state_t;

  localparam int SW            = OW + 1;
  localparam logic [6:0] PT_MAX = 7'd64;

  state_t          state_q, state_d;
  logic [NREQ-1:0] req_q;
  logic [OW-1:0]   rr_ptr, owner_q, win_idx;
  logic            win_found;
  logic [SW-1:0]   cand;
  logic [17:0]     vtx_win;
  logic [11:0]     vtx_q;
  logic            po_take;
  logic            abort_d;
  logic            wdog_hit;
  logic [2:0]      xi_d, yi_d;

  // Requests are registered once; arbitration looks at the registered copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

  // Round-robin search starting one past the pointer, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, rr_ptr} + SW'(i);
      if (cand >= SW'(NREQ)) begin
        cand = cand - SW'(NREQ);
      end
      if (!win_found && req_q[cand[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[OW-1:0];
      end
    end
  end

  assign vtx_win = req_vtx[18*int'(win_idx) +: 18];
  assign po_take = eng_po && (state_q == WAITB || state_q == RUN);

`ifdef TRI_SCHED_WDOG_EN
  logic [9:0] wdog_q;

  assign wdog_hit = (state_q == WAITB || state_q == RUN) &&
                    (wdog_q == 10'(WDOG_CYC - 1));

  // Watchdog counts cycles spent waiting for and running the engine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else if (state_d == WAITB && state_q != WAITB) begin
      wdog_q <= '0;
    end else if (state_q == WAITB || state_q == RUN) begin
      wdog_q <= wdog_q + 10'd1;
    end
  end

  // Abort flag is registered alongside the done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= abort_d;
    end
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign err         = 1'b0;
  assign unused_wdog = ^{10'(WDOG_CYC), abort_d};
`endif

  // Next-state logic; a watchdog hit overrides any state except a normal finish
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE:    if (win_found) state_d = LD1;
      LD1:     state_d = LD2;
      LD2:     state_d = LD3;
      LD3:     state_d = WAITB;
      WAITB:   if (eng_busy) state_d = RUN;
      RUN:     if (!eng_busy) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wdog_hit && state_d != FIN) begin
      state_d = FIN;
      abort_d = 1'b1;
    end
  end

  // Vertex bus value for the upcoming cycle; zero outside the load states
  always_comb begin
    xi_d = 3'd0;
    yi_d = 3'd0;
    case (state_d)
      LD1: begin
        xi_d = vtx_win[17:15];
        yi_d = vtx_win[14:12];
      end
      LD2: begin
        xi_d = vtx_q[11:9];
        yi_d = vtx_q[8:6];
      end
      LD3: begin
        xi_d = vtx_q[5:3];
        yi_d = vtx_q[2:0];
      end
      default: begin
        xi_d = 3'd0;
        yi_d = 3'd0;
      end
    endcase
  end

  // Capture the second and third vertices at the grant edge; later changes are ignored
  always_ff @(posedge clk) begin
    if (state_q == IDLE && win_found) begin
      vtx_q <= vtx_win[11:0];
    end
  end

  // State, grant, engine load, point count and completion registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_ptr  <= OW'(NREQ - 1);
      owner_q <= '0;
      gnt     <= '0;
      done    <= '0;
      pt_cnt  <= '0;
      eng_nt  <= 1'b0;
      eng_xi  <= '0;
      eng_yi  <= '0;
    end else begin
      state_q <= state_d;
      eng_nt  <= (state_d == LD1);
      eng_xi  <= xi_d;
      eng_yi  <= yi_d;
      done    <= '0;
      if (state_q == IDLE && win_found) begin
        owner_q <= win_idx;
        gnt     <= NREQ'(1) << win_idx;
        pt_cnt  <= '0;
      end else if (po_take && pt_cnt != PT_MAX) begin
        pt_cnt  <= pt_cnt + 7'd1;
      end
      if (state_d == FIN) begin
        done   <= NREQ'(1) << owner_q;
        rr_ptr <= owner_q;
      end
      if (state_d == IDLE) begin
        gnt <= '0;
      end
    end
  end

  // Forward engine points, tagged with the current owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      pt_owner <= '0;
    end else begin
      pt_valid <= po_take;
      if (po_take) begin
        pt_x     <= eng_xo;
        pt_y     <= eng_yo;
        pt_owner <= owner_q;
      end
    end
  end

endmodule
